// File: rtl/rom_read_arbiter_pkg.sv
// Shared types for the two-port ROM read arbiter.
// Holds controller states, port-id width and the issue tag layout.
package rom_read_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int PORT_ID_W = 1;

    typedef logic [PORT_ID_W-1:0] port_id_t;

    typedef struct packed {
        port_id_t owner;
        logic     last;
    } tag_t;

endpackage

// File: rtl/rom_read_arbiter_rr.sv
// Two-input round-robin grant with a registered priority pointer.
// The pointer moves to the other port whenever a grant is taken.
module rr_arbiter_2
    import rom_read_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    port_id_t pointer;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            unique case (1'b1)
                (valid0 && !valid1): grant0 = 1'b1;
                (!valid0 && valid1): grant1 = 1'b1;
                (valid0 && valid1): begin
                    grant0 = (pointer == 1'b0);
                    grant1 = (pointer == 1'b1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= '0;
        end else if (grant0) begin
            pointer <= 1'b1;
        end else if (grant1) begin
            pointer <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin burst read arbiter in front of the shared 128x16 ROM.
// Issues one address per cycle and routes tagged data back per port.
module rom_read_arbiter
    import rom_read_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 7,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [ADDRESS_WIDTH-1:0] req0_len,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [ADDRESS_WIDTH-1:0] req1_len,
    output logic                     req1_ready,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_data,
    output logic                     rsp0_last,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_data,
    output logic                     rsp1_last,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic                     rom_cen,
    output logic                     rom_ren,
    input  logic [DATA_WIDTH-1:0]    rom_data
);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_d;
    logic                     cen_q, cen_d;
    port_id_t                 owner_q, owner_d;
    logic                     last_d;
    tag_t                     tag_q;

    logic                     grant0, grant1;
    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] sel_addr, sel_len;

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .enable ((state_q == IDLE) && !reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_len    = grant1 ? req1_len  : req0_len;

    assign rom_cen = cen_q;
    assign rom_ren = cen_q;

    always_comb begin
        state_d = state_q;
        addr_d  = rom_address;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        cen_d   = 1'b0;
        last_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = sel_addr;
                    cnt_d   = sel_len;
                    owner_d = grant1;
                    cen_d   = 1'b1;
                    last_d  = (sel_len == '0);
                    state_d = (sel_len == '0) ? IDLE : BURST;
                end
            end
            BURST: begin
                addr_d = rom_address + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                cen_d  = 1'b1;
                if (cnt_q == ADDRESS_WIDTH'(1)) begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The tag travels with the address so overlapping bursts stay apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rom_address <= '0;
            cnt_q       <= '0;
            cen_q       <= 1'b0;
            owner_q     <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            rom_address <= addr_d;
            cnt_q       <= cnt_d;
            cen_q       <= cen_d;
            owner_q     <= owner_d;
            tag_q       <= '{owner: owner_d, last: last_d};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp0_last  <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_last  <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= cen_q && (tag_q.owner == 1'b0);
            rsp0_last  <= cen_q && (tag_q.owner == 1'b0) && tag_q.last;
            rsp1_valid <= cen_q && (tag_q.owner == 1'b1);
            rsp1_last  <= cen_q && (tag_q.owner == 1'b1) && tag_q.last;
            if (cen_q && (tag_q.owner == 1'b0)) begin
                rsp0_data <= rom_data;
            end
            if (cen_q && (tag_q.owner == 1'b1)) begin
                rsp1_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed scoreboard bench for rom_read_arbiter with a negedge ROM model.
// Beats are queued on accept and popped as responses arrive.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [6:0]  req0_addr = '0, req0_len = '0;
    logic [6:0]  req1_addr = '0, req1_len = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
    logic [15:0] rsp0_data, rsp1_data;
    logic [6:0]  rom_address;
    logic        rom_cen, rom_ren;
    logic [15:0] rom_data = '0;

    typedef struct {
        int          port;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    acc_port[$];
    int    acc_cyc[$];
    int    beat_cyc[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    beats = 0;
    int    cyc = 0;

    rom_read_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_len(req0_len), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_len(req1_len), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_last(rsp0_last),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_last(rsp1_last),
        .rom_address(rom_address), .rom_cen(rom_cen),
        .rom_ren(rom_ren), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romv(input logic [6:0] a);
        return {a, 2'b01, ~a};
    endfunction

    always @(negedge clk)
        if (rom_cen && rom_ren) rom_data <= romv(rom_address);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 0);
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 0);
            chk("rsp_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_port", rsp1_valid ? 1 : 0, e.port);
                chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data,
                    {16'd0, e.data});
                chk("rsp_last", {31'd0, rsp1_valid ? rsp1_last : rsp0_last},
                    {31'd0, e.last});
            end
            beats++;
            beat_cyc.push_back(cyc);
        end
    end

    task automatic req(input int p, input logic [6:0] a,
                       input logic [6:0] l);
        logic got;
        beat_t b;
        got = 1'b0;
        if (p == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_len = l;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_len = l;
        end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                got = 1'b1;
                for (int i = 0; i <= int'(l); i++) begin
                    b.port = p;
                    b.data = romv(a + 7'(i));
                    b.last = (i == int'(l));
                    sb.push_back(b);
                end
                acc_port.push_back(p);
                acc_cyc.push_back(cyc);
            end
        end
        chk("ready_timeout", {31'd0, got}, 1);
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_port.delete();
        acc_cyc.delete();
        beat_cyc.delete();
    endtask

    initial begin
        int b0;
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        // Contention from reset; reset state checked with both valid.
        req0_valid = 1'b1; req0_addr = 7'd40; req0_len = 7'd1;
        req1_valid = 1'b1; req1_addr = 7'd60; req1_len = 7'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 0);
        chk("rst_ready1", {31'd0, req1_ready}, 0);
        chk("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_last", {30'd0, rsp0_last, rsp1_last}, 0);
        chk("rst_rsp_data", {rsp0_data, rsp1_data}, 0);
        chk("rst_rom_en", {30'd0, rom_cen, rom_ren}, 0);
        chk("rst_rom_addr", {25'd0, rom_address}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
        fork
            req(0, 7'd40, 7'd1);
            req(1, 7'd60, 7'd1);
        join
        drain();
        chk("cont_first", acc_port[0], 0);
        chk("cont_second", acc_port[1], 1);
        chk("cont_gap", acc_cyc[1] - acc_cyc[0], 2);
        chk("cont_beats", beat_cyc.size(), 4);
        chk("cont_contig", beat_cyc[3] - beat_cyc[0], 3);

        // Single word.
        @(posedge clk);
        #1;
        req(0, 7'd5, 7'd0);
        chk("sw_addr", {25'd0, rom_address}, 5);
        chk("sw_en", {30'd0, rom_cen, rom_ren}, 3);
        @(posedge clk);
        #1;
        chk("sw_en_off", {30'd0, rom_cen, rom_ren}, 0);
        chk("sw_addr_hold", {25'd0, rom_address}, 5);
        drain();

        // Burst with address wrap on port 1.
        clear_logs();
        @(posedge clk);
        #1;
        req(1, 7'd126, 7'd3);
        drain();
        chk("wrap_beats", beat_cyc.size(), 4);
        chk("wrap_contig", beat_cyc[3] - beat_cyc[0], 3);

        // Persistent contention, six single-word bursts.
        clear_logs();
        @(posedge clk);
        #1;
        fork
            begin
                req(0, 7'd1, 7'd0); req(0, 7'd2, 7'd0); req(0, 7'd3, 7'd0);
            end
            begin
                req(1, 7'd9, 7'd0); req(1, 7'd8, 7'd0); req(1, 7'd7, 7'd0);
            end
        join
        drain();
        for (int i = 0; i < 6; i++) begin
            chk("alt_port", acc_port[i], i % 2);
            if (i > 0) chk("alt_gap", acc_cyc[i] - acc_cyc[i-1], 1);
        end

        // Reset in the middle of a burst.
        @(posedge clk);
        #1;
        b0 = beats;
        req(0, 7'd20, 7'd9);
        for (int n = 0; n < 50 && beats < b0 + 3; n++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_beats", beats - b0, 3);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0 = beats;
        @(negedge clk);
        chk("mr_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
        chk("mr_rsp_last", {30'd0, rsp0_last, rsp1_last}, 0);
        chk("mr_rsp_data", {rsp0_data, rsp1_data}, 0);
        chk("mr_rom_en", {30'd0, rom_cen, rom_ren}, 0);
        chk("mr_rom_addr", {25'd0, rom_address}, 0);
        repeat (12) @(negedge clk);
        chk("mr_no_rsp", beats, b0);
        @(posedge clk);
        #1;
        req(0, 7'd10, 7'd2);
        drain();
        chk("mr_new_beats", beats - b0, 3);

        // Full-range burst with port 1 kept waiting.
        clear_logs();
        @(posedge clk);
        #1;
        fork
            req(0, 7'd0, 7'd127);
            begin
                repeat (3) @(posedge clk);
                #1;
                req(1, 7'd33, 7'd0);
            end
        join
        drain();
        chk("full_wait", acc_cyc[1] - acc_cyc[0], 128);
        chk("full_beats", beat_cyc.size(), 129);
        chk("full_contig", beat_cyc[127] - beat_cyc[0], 127);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
